pipelined_barrel_shifter: RTL and testbench

//   Parametrised N-bit barrel shifter with a run-time shift amount and four shift modes.

---
 rtl/shift_pkg.sv | 48 ++++
 rtl/shifter_stage.sv | 64 ++++++
 rtl/pipelined_barrel_shifter.sv | 68 ++++++
 tb/tb_pipelined_barrel_shifter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and the single-stage shift step for the pipelined barrel shifter.
// Combinational only: no state and no latency of its own.
// No handshake at this level; flow control is done in shifter_stage.
package shift_pkg;

    // Widest operand the stage step function supports.
    localparam int MAX_N = 64;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2,
        ROR = 2'd3
    } shift_op_t;

    // One log-shifter step. It shifts by 2**k when en is set, and passes the data through otherwise.
    // The operand sits in the low n bits of data and the upper bits must be zero.
    // The sign bit is the MSB of the original operand and fills vacated bits for SRA.
    // k and n are elaboration constants at every call site, so each shift is fixed wiring.
    function automatic logic [MAX_N-1:0] shift_stage_f(
        input logic [MAX_N-1:0] data,
        input logic             sign,
        input shift_op_t        op,
        input logic             en,
        input int               k,
        input int               n
    );
        logic [MAX_N-1:0] mask;
        logic [MAX_N-1:0] res;
        int               sh;
        sh = 1 << k;
        for (int i = 0; i < MAX_N; i++) begin
            mask[i] = (i < n);
        end
        res = data;
        if (en) begin
            case (op)
                SLL:     res = (data << sh) & mask;
                SRL:     res = data >> sh;
                SRA:     res = (data >> sh) | (sign ? (mask & ~(mask >> sh)) : '0);
                ROR:     res = ((data >> sh) | (data << (n - sh))) & mask;
                default: res = data;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One registered shift stage. It shifts by 2**K when amount bit K is set.
// Latency: 1 cycle.
// Backpressure: the stage loads when it is empty or when downstream is ready, so a stall holds only full stages.
module shifter_stage
    import shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = 3,
    parameter int K  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_amt,
    input  shift_op_t     in_op,
    input  logic          in_sign,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [N-1:0]  out_data,
    output logic [SW-1:0] out_amt,
    output shift_op_t     out_op,
    output logic          out_sign
);

    logic [MAX_N-1:0] data_ext;
    logic [MAX_N-1:0] step;

    // Zero-extend the operand into the width used by the package step function.
    always_comb begin
        data_ext         = '0;
        data_ext[N-1:0]  = in_data;
    end

    assign step   = shift_stage_f(data_ext, in_sign, in_op, in_amt[K], K, N);
    assign in_rdy = !out_vld || out_rdy;

    if (N < MAX_N) begin : g_hi
        // Bits above N are always zero and are not used.
        logic unused_hi;
        assign unused_hi = ^step[MAX_N-1:N];
    end

    // Stage register. valid follows upstream on every load and the payload loads only with a real beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_amt  <= '0;
            out_op   <= SLL;
            out_sign <= 1'b0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_data <= step[N-1:0];
                out_amt  <= in_amt;
                out_op   <= in_op;
                out_sign <= in_sign;
            end
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// N-bit barrel shifter with SLL/SRL/SRA/ROR modes and a run-time amount, built from SW = log2(N) stages.
// Latency: SW cycles from input transfer to down_valid when there is no stall. Throughput is 1 beat per cycle.
// Backpressure: per-stage valid/ready. Bubbles collapse ahead of a stall and up_ready drops only when stage 0 is full and blocked.
module pipelined_barrel_shifter
    import shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_amt,
    input  logic [1:0]    up_op,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    // Index 0 of each chain is the upstream port and index k+1 is the output of stage k.
    logic [SW:0]   vld_c;
    logic [SW:0]   rdy_c;
    logic [SW:0]   sign_c;
    logic [N-1:0]  data_c [0:SW];
    logic [SW-1:0] amt_c  [0:SW];
    shift_op_t     op_c   [0:SW];

    assign vld_c[0]   = up_valid;
    assign data_c[0]  = up_data;
    assign amt_c[0]   = up_amt;
    assign op_c[0]    = shift_op_t'(up_op);
    assign sign_c[0]  = up_data[N-1];
    assign up_ready   = rdy_c[0];

    assign rdy_c[SW]  = down_ready;
    assign down_valid = vld_c[SW];
    assign down_data  = data_c[SW];

    for (genvar k = 0; k < SW; k++) begin : g_stage
        shifter_stage #(
            .N  (N),
            .SW (SW),
            .K  (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_vld   (vld_c[k]),
            .in_rdy   (rdy_c[k]),
            .in_data  (data_c[k]),
            .in_amt   (amt_c[k]),
            .in_op    (op_c[k]),
            .in_sign  (sign_c[k]),
            .out_vld  (vld_c[k+1]),
            .out_rdy  (rdy_c[k+1]),
            .out_data (data_c[k+1]),
            .out_amt  (amt_c[k+1]),
            .out_op   (op_c[k+1]),
            .out_sign (sign_c[k+1])
        );
    end

    // The amount, op and sign of the last stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^{amt_c[SW], op_c[SW], sign_c[SW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

    logic clk;
    logic rst_n;

    // N = 8 instance
    logic       v8, r8, dv8, dr8;
    logic [7:0] d8, dd8;
    logic [2:0] a8;
    logic [1:0] o8;

    // N = 32 instance
    logic        v32, r32, dv32, dr32;
    logic [31:0] d32, dd32;
    logic [4:0]  a32;
    logic [1:0]  o32;

    int checks   = 0;
    int failures = 0;

    pipelined_barrel_shifter #(.N(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (v8),
        .up_ready   (r8),
        .up_data    (d8),
        .up_amt     (a8),
        .up_op      (o8),
        .down_valid (dv8),
        .down_ready (dr8),
        .down_data  (dd8)
    );

    pipelined_barrel_shifter #(.N(32)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (v32),
        .up_ready   (r32),
        .up_data    (d32),
        .up_amt     (a32),
        .up_op      (o32),
        .down_valid (dv32),
        .down_ready (dr32),
        .down_data  (dd32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model, built bit by bit from the definition of each shift mode.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a, input int op, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                0:       r[i] = (i >= a)    ? d[i-a] : 1'b0;
                1:       r[i] = (i + a < w) ? d[i+a] : 1'b0;
                2:       r[i] = (i + a < w) ? d[i+a] : d[w-1];
                default: r[i] = d[(i + a) % w];
            endcase
        end
        return r;
    endfunction

    task automatic test_reset();
        int seen;
        @(negedge clk); #1;
        checks++; if (dv8 !== 1'b0)  begin failures++; $display("FAIL reset_dv: got %b want 0", dv8); end
        checks++; if (dd8 !== 8'h00) begin failures++; $display("FAIL reset_dd: got %h want 00", dd8); end
        checks++; if (r8 !== 1'b1)   begin failures++; $display("FAIL reset_rdy: got %b want 1", r8); end
        checks++; if (dv32 !== 1'b0) begin failures++; $display("FAIL reset_dv32: got %b want 0", dv32); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (r8 !== 1'b1) begin failures++; $display("FAIL post_reset_rdy: got %b want 1", r8); end
        // put three beats in flight behind a stalled output
        dr8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v8 = 1'b1; d8 = 8'($urandom); a8 = 3'($urandom); o8 = 2'($urandom);
            @(negedge clk);
        end
        v8 = 1'b0;
        #1;
        checks++; if (dv8 !== 1'b1) begin failures++; $display("FAIL inflight_dv: got %b want 1", dv8); end
        rst_n = 1'b0;
        #1;
        checks++; if (dv8 !== 1'b0)  begin failures++; $display("FAIL midreset_dv: got %b want 0", dv8); end
        checks++; if (r8 !== 1'b1)   begin failures++; $display("FAIL midreset_rdy: got %b want 1", r8); end
        checks++; if (dd8 !== 8'h00) begin failures++; $display("FAIL midreset_dd: got %h want 00", dd8); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dr8   = 1'b1;
        #1;
        checks++; if (dv8 !== 1'b0) begin failures++; $display("FAIL release_dv: got %b want 0", dv8); end
        checks++; if (r8 !== 1'b1)  begin failures++; $display("FAIL release_rdy: got %b want 1", r8); end
        seen = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (dv8) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL stale_beats: got %0d want 0", seen); end
    endtask

    task automatic test_modes();
        logic [7:0] exp_tab [4];
        logic [7:0] got;
        int         lat;
        exp_tab = '{8'hA0, 8'h16, 8'hF6, 8'h96};
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            v8 = 1'b1; d8 = 8'hB4; a8 = 3'd3; o8 = 2'(m); dr8 = 1'b1;
            @(negedge clk);
            v8 = 1'b0;
            lat = 0; got = '0;
            for (int c = 1; c <= 10 && lat == 0; c++) begin
                #1;
                if (dv8) begin lat = c; got = dd8; end
                else @(negedge clk);
            end
            checks++; if (lat !== 3) begin failures++; $display("FAIL mode%0d_latency: got %0d want 3", m, lat); end
            checks++; if (got !== exp_tab[m]) begin failures++; $display("FAIL mode%0d_data: got %h want %h", m, got, exp_tab[m]); end
        end
    endtask

    task automatic test_edges();
        logic [7:0] ed [7];
        logic [2:0] ea [7];
        logic [1:0] eo [7];
        logic [7:0] ex [7];
        logic [7:0] got;
        int         lat;
        ed = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h80, 8'h01, 8'h01};
        ea = '{3'd0,  3'd0,  3'd0,  3'd0,  3'd7,  3'd7,  3'd7};
        eo = '{2'd0,  2'd1,  2'd2,  2'd3,  2'd2,  2'd3,  2'd0};
        ex = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'hFF, 8'h02, 8'h80};
        for (int e = 0; e < 7; e++) begin
            @(negedge clk);
            v8 = 1'b1; d8 = ed[e]; a8 = ea[e]; o8 = eo[e]; dr8 = 1'b1;
            @(negedge clk);
            v8 = 1'b0;
            lat = 0; got = '0;
            for (int c = 1; c <= 10 && lat == 0; c++) begin
                #1;
                if (dv8) begin lat = c; got = dd8; end
                else @(negedge clk);
            end
            checks++; if (got !== ex[e] || lat == 0) begin failures++; $display("FAIL edge%0d: got %h (lat %0d) want %h", e, got, lat, ex[e]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  q [$];
        logic [7:0]  want;
        logic [31:0] m;
        int sent, got, first_cyc, last_cyc, rdy_low;
        sent = 0; got = 0; first_cyc = -1; last_cyc = -1; rdy_low = 0;
        dr8 = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
            @(negedge clk);
            v8 = (sent < 16);
            d8 = 8'($urandom); a8 = 3'($urandom); o8 = 2'($urandom);
            #1;
            if (dv8) begin
                want = (q.size() > 0) ? q.pop_front() : 8'hxx;
                checks++; if (dd8 !== want) begin failures++; $display("FAIL b2b_data%0d: got %h want %h", got, dd8, want); end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (v8) begin
                if (!r8) rdy_low++;
                else begin
                    m = ref_shift({24'b0, d8}, int'(a8), int'(o8), 8);
                    q.push_back(m[7:0]);
                    sent++;
                end
            end
        end
        v8 = 1'b0;
        checks++; if (rdy_low !== 0) begin failures++; $display("FAIL b2b_ready: got %0d low cycles want 0", rdy_low); end
        checks++; if (got !== 16) begin failures++; $display("FAIL b2b_count: got %0d want 16", got); end
        checks++; if (last_cyc - first_cyc !== 15) begin failures++; $display("FAIL b2b_consecutive: got span %0d want 15", last_cyc - first_cyc); end
    endtask

    task automatic test_backpressure();
        logic [7:0]  q [$];
        logic [7:0]  bd [4];
        logic [2:0]  ba [4];
        logic [1:0]  bo [4];
        logic [7:0]  want;
        logic [31:0] m;
        int sent, got;
        sent = 0; got = 0;
        for (int i = 0; i < 4; i++) begin
            bd[i] = 8'($urandom); ba[i] = 3'($urandom); bo[i] = 2'($urandom);
        end
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            dr8 = (cyc >= 8);
            v8  = (sent < 4);
            if (sent < 4) begin d8 = bd[sent]; a8 = ba[sent]; o8 = bo[sent]; end
            #1;
            if (cyc >= 3 && cyc < 8) begin
                checks++; if (r8 !== 1'b0) begin failures++; $display("FAIL bp_ready_c%0d: got %b want 0", cyc, r8); end
                checks++; if (dv8 !== 1'b1 || dd8 !== q[0]) begin failures++; $display("FAIL bp_hold_c%0d: got %b/%h want 1/%h", cyc, dv8, dd8, q[0]); end
            end
            if (dv8 && dr8) begin
                want = (q.size() > 0) ? q.pop_front() : 8'hxx;
                checks++; if (dd8 !== want) begin failures++; $display("FAIL bp_data%0d: got %h want %h", got, dd8, want); end
                got++;
            end
            if (v8 && r8) begin
                m = ref_shift({24'b0, d8}, int'(a8), int'(o8), 8);
                q.push_back(m[7:0]);
                sent++;
            end
        end
        v8  = 1'b0;
        dr8 = 1'b1;
        checks++; if (got !== 4 || sent !== 4) begin failures++; $display("FAIL bp_count: got %0d out / %0d in want 4/4", got, sent); end
    endtask

    task automatic test_random32();
        logic [31:0] q [$];
        logic [31:0] want, prev_dd;
        int sent, got, held_bad;
        logic pending, prev_stall;
        sent = 0; got = 0; held_bad = 0; pending = 1'b0; prev_stall = 1'b0; prev_dd = '0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            @(negedge clk);
            if (!pending) begin
                v32 = (sent < 1000) && ($urandom_range(0, 99) < 70);
                d32 = $urandom; a32 = 5'($urandom); o32 = 2'($urandom);
            end
            dr32 = ($urandom_range(0, 1) == 1);
            #1;
            if (prev_stall && (dv32 !== 1'b1 || dd32 !== prev_dd)) held_bad++;
            if (dv32 && dr32) begin
                want = (q.size() > 0) ? q.pop_front() : 32'hxxxxxxxx;
                checks++; if (dd32 !== want) begin failures++; $display("FAIL rand32_beat%0d: got %h want %h", got, dd32, want); end
                got++;
            end
            prev_stall = dv32 && !dr32;
            prev_dd    = dd32;
            if (v32 && r32) begin
                q.push_back(ref_shift(d32, int'(a32), int'(o32), 32));
                sent++;
                pending = 1'b0;
            end else begin
                pending = v32;
            end
        end
        v32  = 1'b0;
        dr32 = 1'b1;
        checks++; if (got !== 1000) begin failures++; $display("FAIL rand32_count: got %0d want 1000", got); end
        checks++; if (held_bad !== 0) begin failures++; $display("FAIL rand32_stable: got %0d unstable stalls want 0", held_bad); end
    endtask

    initial begin
        rst_n = 1'b0;
        v8 = 1'b0; d8 = '0; a8 = '0; o8 = '0; dr8 = 1'b1;
        v32 = 1'b0; d32 = '0; a32 = '0; o32 = '0; dr32 = 1'b1;
        test_reset();
        test_modes();
        test_edges();
        test_back_to_back();
        test_backpressure();
        test_random32();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
